// File: rtl/hms_pkg.sv
// Shared constants and types for the HH:MM:SS time-keeper and its segment decoders.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hms_pkg;

    // Active-low seven-segment patterns, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    // Digit limits of the BCD counter chain.
    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [6:0] HR_MAX       = 7'd23;

    // Six-digit BCD time, always held in 24 h form.
    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_u;
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } hms_t;

    // Two BCD digits to binary (0..99).
    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to an active-low seven-segment pattern; codes above 9 or blank show nothing.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (digit), blank (force all segments off), seg (active-low a..g on bits 0..6).
module seg7_decode
    import hms_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hms_timer_display.sv
// HH:MM:SS up/down time-keeper with prescaled 1 s tick, validated BCD preset and 6-digit seven-segment output.
// Latency: state/sec_tick/zero/load_err update on the tick or load edge; hex*/pm lag the state by 1 clk.
// Backpressure: none; load has priority over a coincident tick, which is dropped.
// Ports: clk, rst (async active-low), run/down/mode12 controls, load + load_hh/mm/ss BCD preset,
//        hex5..hex0 active-low segments (hex5 = hour tens), sec_tick, pm, zero (sticky), load_err.
module hms_timer_display
    import hms_pkg::*;
#(
    parameter int TICK_DIV      = 50_000_000,
    parameter bit BLANK_HR_LEAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       down,
    input  logic       mode12,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       sec_tick,
    output logic       pm,
    output logic       zero,
    output logic       load_err
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] presc;
    hms_t          cur;
    hms_t          inc_t;
    hms_t          dec_t;
    hms_t          load_t;
    logic          load_ok;
    logic [6:0]    hr_bin;
    logic [6:0]    disp_hr;
    logic [3:0]    dig [6];
    logic [5:0]    blk;
    logic [6:0]    seg_nxt [6];

    assign load_t = '{hr_t: load_hh[7:4], hr_u: load_hh[3:0],
                      min_t: load_mm[7:4], min_u: load_mm[3:0],
                      sec_t: load_ss[7:4], sec_u: load_ss[3:0]};

    // Nibble checks bound each units digit to 9; tens limits then bound mm/ss to 59.
    assign load_ok = (load_hh[3:0] <= UNITS_MAX) && (load_hh[7:4] <= UNITS_MAX)
                  && (bcd2bin(load_hh) <= HR_MAX)
                  && (load_mm[3:0] <= UNITS_MAX) && (load_mm[7:4] <= MIN_TENS_MAX)
                  && (load_ss[3:0] <= UNITS_MAX) && (load_ss[7:4] <= SEC_TENS_MAX);

    // Increment with carry; 23:59:59 wraps to 00:00:00.
    always_comb begin
        inc_t = cur;
        if (cur.sec_u != UNITS_MAX) begin
            inc_t.sec_u = cur.sec_u + 4'd1;
        end else begin
            inc_t.sec_u = 4'd0;
            if (cur.sec_t != SEC_TENS_MAX) begin
                inc_t.sec_t = cur.sec_t + 4'd1;
            end else begin
                inc_t.sec_t = 4'd0;
                if (cur.min_u != UNITS_MAX) begin
                    inc_t.min_u = cur.min_u + 4'd1;
                end else begin
                    inc_t.min_u = 4'd0;
                    if (cur.min_t != MIN_TENS_MAX) begin
                        inc_t.min_t = cur.min_t + 4'd1;
                    end else begin
                        inc_t.min_t = 4'd0;
                        if (hr_bin == HR_MAX) begin
                            inc_t.hr_t = 4'd0;
                            inc_t.hr_u = 4'd0;
                        end else if (cur.hr_u == UNITS_MAX) begin
                            inc_t.hr_u = 4'd0;
                            inc_t.hr_t = cur.hr_t + 4'd1;
                        end else begin
                            inc_t.hr_u = cur.hr_u + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Decrement with borrow; 00:00:00 is a floor, never wrapped.
    always_comb begin
        dec_t = cur;
        if (cur != '0) begin
            if (cur.sec_u != 4'd0) begin
                dec_t.sec_u = cur.sec_u - 4'd1;
            end else begin
                dec_t.sec_u = UNITS_MAX;
                if (cur.sec_t != 4'd0) begin
                    dec_t.sec_t = cur.sec_t - 4'd1;
                end else begin
                    dec_t.sec_t = SEC_TENS_MAX;
                    if (cur.min_u != 4'd0) begin
                        dec_t.min_u = cur.min_u - 4'd1;
                    end else begin
                        dec_t.min_u = UNITS_MAX;
                        if (cur.min_t != 4'd0) begin
                            dec_t.min_t = cur.min_t - 4'd1;
                        end else begin
                            dec_t.min_t = MIN_TENS_MAX;
                            if (cur.hr_u != 4'd0) begin
                                dec_t.hr_u = cur.hr_u - 4'd1;
                            end else begin
                                dec_t.hr_u = UNITS_MAX;
                                dec_t.hr_t = cur.hr_t - 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Prescaler, time state and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            cur      <= '0;
            sec_tick <= 1'b0;
            zero     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (load) begin
                // A load attempt swallows any tick due on this edge.
                if (load_ok) begin
                    cur      <= load_t;
                    presc    <= '0;
                    zero     <= 1'b0;
                    load_err <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (run) begin
                if (presc == LAST) begin
                    presc    <= '0;
                    sec_tick <= 1'b1;
                    if (down) begin
                        cur <= dec_t;
                        // Covers both arriving at zero and ticking while parked there.
                        if (dec_t == '0) begin
                            zero <= 1'b1;
                        end
                    end else begin
                        cur  <= inc_t;
                        zero <= 1'b0;
                    end
                end else begin
                    presc <= presc + CW'(1);
                end
            end
        end
    end

    // 12 h formatting touches only the displayed hour.
    assign hr_bin = bcd2bin({cur.hr_t, cur.hr_u});

    always_comb begin
        disp_hr = hr_bin;
        if (mode12) begin
            if (hr_bin == 7'd0) begin
                disp_hr = 7'd12;
            end else if (hr_bin > 7'd12) begin
                disp_hr = hr_bin - 7'd12;
            end
        end
        dig[0] = cur.sec_u;
        dig[1] = cur.sec_t;
        dig[2] = cur.min_u;
        dig[3] = cur.min_t;
        if (disp_hr >= 7'd20) begin
            dig[5] = 4'd2;
            dig[4] = 4'(disp_hr - 7'd20);
        end else if (disp_hr >= 7'd10) begin
            dig[5] = 4'd1;
            dig[4] = 4'(disp_hr - 7'd10);
        end else begin
            dig[5] = 4'd0;
            dig[4] = 4'(disp_hr);
        end
    end

    assign blk = {(BLANK_HR_LEAD && (dig[5] == 4'd0)), 5'b00000};

    for (genvar i = 0; i < 6; i++) begin : g_dec
        seg7_decode u_dec (
            .bcd   (dig[i]),
            .blank (blk[i]),
            .seg   (seg_nxt[i])
        );
    end

    // Output registers: display and pm follow the state one clock later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hex5 <= BLANK_HR_LEAD ? SEG_BLANK : SEG_DIGIT[0];
            hex4 <= SEG_DIGIT[0];
            hex3 <= SEG_DIGIT[0];
            hex2 <= SEG_DIGIT[0];
            hex1 <= SEG_DIGIT[0];
            hex0 <= SEG_DIGIT[0];
            pm   <= 1'b0;
        end else begin
            hex5 <= seg_nxt[5];
            hex4 <= seg_nxt[4];
            hex3 <= seg_nxt[3];
            hex2 <= seg_nxt[2];
            hex1 <= seg_nxt[1];
            hex0 <= seg_nxt[0];
            pm   <= (hr_bin >= 7'd12);
        end
    end

endmodule

// File: tb/tb_hms_timer_display.sv
module tb_hms_timer_display;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       down = 1'b0;
    logic       mode12 = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hh = 8'h00;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic       sec_tick, pm, zero, load_err;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q [$];
    string       tag_q [$];

    hms_timer_display #(.TICK_DIV(TD), .BLANK_HR_LEAD(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .down     (down),
        .mode12   (mode12),
        .load     (load),
        .load_hh  (load_hh),
        .load_mm  (load_mm),
        .load_ss  (load_ss),
        .hex5     (hex5),
        .hex4     (hex4),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .sec_tick (sec_tick),
        .pm       (pm),
        .zero     (zero),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h18;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {pm, hex5..hex0} for a 24 h internal time.
    function automatic logic [63:0] disp(input int h, input int m, input int s, input bit m12);
        int dh;
        logic [6:0] h5;
        dh = h;
        if (m12) begin
            if (h == 0) dh = 12;
            else if (h > 12) dh = h - 12;
        end
        h5 = (dh / 10 == 0) ? 7'h7F : seg_of(dh / 10);
        return {21'd0, (h >= 12), h5, seg_of(dh % 10), seg_of(m / 10), seg_of(m % 10),
                seg_of(s / 10), seg_of(s % 10)};
    endfunction

    function automatic logic [63:0] flags(input bit t, input bit z, input bit e);
        return {61'd0, t, z, e};
    endfunction

    function automatic logic [63:0] obs_disp();
        return {21'd0, pm, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    function automatic logic [63:0] obs_flags();
        return {61'd0, sec_tick, zero, load_err};
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_next(input logic [63:0] obs);
        logic [63:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_raw(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load_hh = h;
        load_mm = m;
        load_ss = s;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic load_time(input int h, input int m, input int s);
        load_raw(bcd(h), bcd(m), bcd(s));
    endtask

    // Steps until sec_tick is seen, bounded by two prescaler periods.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        expect_val(tag, 64'd1);
        do begin
            step();
            n++;
        end while (sec_tick !== 1'b1 && n < 2 * TD);
        check_next({63'd0, sec_tick});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int seen;

        // Reset values while rst is held low across an edge.
        #12;
        expect_val("reset_disp", disp(0, 0, 0, 0));
        check_next(obs_disp());
        expect_val("reset_flags", flags(0, 0, 0));
        check_next(obs_flags());

        // First tick on the 4th edge after release.
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b1;
        step(); step(); step();
        expect_val("pre_first_tick", flags(0, 0, 0));
        check_next(obs_flags());
        step();
        expect_val("first_tick", flags(1, 0, 0));
        check_next(obs_flags());
        expect_val("disp_lags_tick", disp(0, 0, 0, 0));
        check_next(obs_disp());
        step();
        expect_val("disp_00_00_01", disp(0, 0, 1, 0));
        check_next(obs_disp());

        // Full rollover 23:59:59 -> 00:00:00.
        load_time(23, 59, 59);
        step();
        expect_val("disp_23_59_59", disp(23, 59, 59, 0));
        check_next(obs_disp());
        wait_tick("rollover_tick");
        expect_val("rollover_flags", flags(1, 0, 0));
        check_next(obs_flags());
        step();
        expect_val("rollover_disp", disp(0, 0, 0, 0));
        check_next(obs_disp());

        // 12 h formatting.
        mode12 = 1'b1;
        load_time(11, 59, 59);
        step();
        expect_val("m12_11_59_59", disp(11, 59, 59, 1));
        check_next(obs_disp());
        wait_tick("m12_noon_tick");
        step();
        expect_val("m12_noon", disp(12, 0, 0, 1));
        check_next(obs_disp());
        load_time(0, 30, 0);
        step();
        expect_val("m12_midnight", disp(0, 30, 0, 1));
        check_next(obs_disp());
        load_time(13, 5, 0);
        step();
        expect_val("m12_13h", disp(13, 5, 0, 1));
        check_next(obs_disp());
        mode12 = 1'b0;
        step();
        expect_val("m24_13h", disp(13, 5, 0, 0));
        check_next(obs_disp());

        // Countdown to zero and hold.
        down = 1'b1;
        load_time(0, 0, 2);
        wait_tick("down_tick1");
        expect_val("down_flags1", flags(1, 0, 0));
        check_next(obs_flags());
        wait_tick("down_tick2");
        expect_val("down_zero", flags(1, 1, 0));
        check_next(obs_flags());
        step();
        expect_val("down_disp_zero", disp(0, 0, 0, 0));
        check_next(obs_disp());
        wait_tick("down_tick3");
        expect_val("down_hold_flags", flags(1, 1, 0));
        check_next(obs_flags());
        step();
        expect_val("down_hold_disp", disp(0, 0, 0, 0));
        check_next(obs_disp());
        load_time(0, 0, 5);
        expect_val("load_clears_zero", flags(0, 0, 0));
        check_next(obs_flags());

        // Rejected loads leave the state alone.
        run = 1'b0;
        down = 1'b0;
        load_raw(8'h24, 8'h00, 8'h00);
        expect_val("reject_24h", flags(0, 0, 1));
        check_next(obs_flags());
        step();
        expect_val("reject_24h_disp", disp(0, 0, 5, 0));
        check_next(obs_disp());
        load_raw(8'h00, 8'h00, 8'h1A);
        expect_val("reject_ss1a", flags(0, 0, 1));
        check_next(obs_flags());
        step();
        expect_val("reject_ss1a_disp", disp(0, 0, 5, 0));
        check_next(obs_disp());

        // Load coinciding with a tick edge.
        run = 1'b1;
        load_time(1, 2, 3);
        expect_val("accept_clears_err", flags(0, 0, 0));
        check_next(obs_flags());
        step(); step(); step();
        load_time(10, 20, 30);
        expect_val("load_on_tick_flags", flags(0, 0, 0));
        check_next(obs_flags());
        step();
        expect_val("load_on_tick_disp", disp(10, 20, 30, 0));
        check_next(obs_disp());
        step(); step();
        expect_val("presc_cleared_pre", flags(0, 0, 0));
        check_next(obs_flags());
        step();
        expect_val("presc_cleared_tick", flags(1, 0, 0));
        check_next(obs_flags());

        // Pause for 10 cycles with the prescaler part-way.
        step(); step();
        run = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sec_tick === 1'b1) seen++;
        end
        expect_val("pause_no_ticks", 64'd0);
        check_next(64'(seen));
        run = 1'b1;
        step();
        expect_val("resume_pre", flags(0, 0, 0));
        check_next(obs_flags());
        step();
        expect_val("resume_tick", flags(1, 0, 0));
        check_next(obs_flags());

        // Asynchronous reset between edges.
        load_raw(8'h99, 8'h00, 8'h00);
        #3;
        rst = 1'b0;
        #1;
        expect_val("async_rst_disp", disp(0, 0, 0, 0));
        check_next(obs_disp());
        expect_val("async_rst_flags", flags(0, 0, 0));
        check_next(obs_flags());
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(); step(); step();
        expect_val("post_rst_pre", flags(0, 0, 0));
        check_next(obs_flags());
        step();
        expect_val("post_rst_tick", flags(1, 0, 0));
        check_next(obs_flags());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
